// File: rtl/mem_responder.sv
// Word-organised data memory acting as the responder on a valid/ready load/store port,
// with WAIT_CYCLES wait states. Define MEM_RESPONDER_STATS_EN to add response counters.
module mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] err_count
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;
  logic               wr_q, wr_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        mem_q [DEPTH];

  logic               accept_c;
  logic               commit_c;
  logic               resp_hs_c;
  logic               wr_c;
  logic [31:0]        addr_c;
  logic [31:0]        wdata_c;
  logic [3:0]         be_c;
  logic               addr_err_c;
  logic [ADDR_W-1:0]  idx_c;

  assign accept_c  = (state_q == ST_IDLE) && req_valid && req_ready_q;
  assign resp_hs_c = (state_q == ST_RESP) && resp_ready;
  assign commit_c  = (state_q != ST_RESP) && (state_d == ST_RESP);

  // With zero wait states the commit edge is the acceptance edge, so use live inputs in IDLE
  assign wr_c    = (state_q == ST_IDLE) ? req_wr    : wr_q;
  assign addr_c  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign wdata_c = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign be_c    = (state_q == ST_IDLE) ? req_be    : be_q;

  assign addr_err_c = (addr_c[1:0] != 2'b00) || ((addr_c >> (ADDR_W + 2)) != 32'd0);
  assign idx_c      = addr_c[ADDR_W+1:2];

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
    end
  end

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 32'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and request latch; req_ready stays low for one IDLE cycle after a response
  always_comb begin
    req_ready_d  = (state_q == ST_IDLE) && !accept_c;
    resp_valid_d = (state_d == ST_RESP);
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    if (accept_c) begin
      wr_d    = req_wr;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      be_d    = req_be;
    end
    if (commit_c) begin
      resp_err_d   = addr_err_c;
      resp_rdata_d = (addr_err_c || wr_c) ? 32'd0 : mem_q[idx_c];
    end else if (resp_hs_c) begin
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'd0;
    end
  end

  // Byte-lane store on the commit edge; suppressed by a coincident reset
  always_ff @(posedge clk) begin
    if (!rst && commit_c && wr_c && !addr_err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) begin
          mem_q[idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

  // Saturating counters stepped on the response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (resp_hs_c) begin
      if (resp_err_q) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= 16'(err_cnt_q + 16'd1);
      end else if (wr_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= 16'(wr_cnt_q + 16'd1);
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= 16'(rd_cnt_q + 16'd1);
      end
    end
  end

  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance a has two wait states, instance b has none.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a, req_valid_b;
  logic        req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_ready;
  logic        req_ready_a, resp_valid_a, resp_err_a;
  logic [31:0] resp_rdata_a;
  logic        req_ready_b, resp_valid_b, resp_err_b;
  logic [31:0] resp_rdata_b;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] rd_a, wr_a, err_a, rd_b, wr_b, err_b;
`endif

  int total  = 0;
  int passed = 0;

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready), .resp_rdata(resp_rdata_a),
    .resp_err(resp_err_a)
`ifdef MEM_RESPONDER_STATS_EN
    , .rd_count(rd_a), .wr_count(wr_a), .err_count(err_a)
`endif
  );

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp_rdata(resp_rdata_b),
    .resp_err(resp_err_b)
`ifdef MEM_RESPONDER_STATS_EN
    , .rd_count(rd_b), .wr_count(wr_b), .err_count(err_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? req_ready_b : req_ready_a;
  endfunction

  function automatic logic vld(input bit sel);
    return sel ? resp_valid_b : resp_valid_a;
  endfunction

  function automatic logic [31:0] rdat(input bit sel);
    return sel ? resp_rdata_b : resp_rdata_a;
  endfunction

  function automatic logic errf(input bit sel);
    return sel ? resp_err_b : resp_err_a;
  endfunction

  // One full transaction with resp_ready held high; inputs are scrambled after acceptance
  task automatic txn(input bit sel, input string name, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input logic exp_err,
                     input logic [31:0] exp_rdata, input int exp_lat);
    int n;
    n = 0;
    while (!rdy(sel) && n < 10) begin tick(); n++; end
    chk({name, " req_ready"}, 32'(rdy(sel)), 32'd1);
    req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_wr = ~wr; req_addr = ~addr; req_wdata = ~wdata; req_be = ~be;
    n = 1;
    while (!vld(sel) && n < 20) begin tick(); n++; end
    chk({name, " latency"}, 32'(n), 32'(exp_lat));
    chk({name, " resp_err"}, 32'(errf(sel)), 32'(exp_err));
    chk({name, " resp_rdata"}, rdat(sel), exp_rdata);
    tick();
    chk({name, " valid after hs"}, 32'(vld(sel)), 32'd0);
    chk({name, " rdata after hs"}, rdat(sel), 32'd0);
    chk({name, " ready gap"}, 32'(rdy(sel)), 32'd0);
    tick();
    chk({name, " ready back"}, 32'(rdy(sel)), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " req_ready"}, 32'(req_ready_a), 32'd1);
    chk({name, " resp_valid"}, 32'(resp_valid_a), 32'd0);
    chk({name, " resp_rdata"}, resp_rdata_a, 32'd0);
    chk({name, " resp_err"}, 32'(resp_err_a), 32'd0);
`ifdef MEM_RESPONDER_STATS_EN
    chk({name, " rd_count"}, 32'(rd_a), 32'd0);
    chk({name, " wr_count"}, 32'(wr_a), 32'd0);
    chk({name, " err_count"}, 32'(err_a), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int rv;
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'b1111, 1'b0, 32'h11BB_33DD};
    vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0,         4'b1111, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_1000, 32'h0,         4'b1111, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 1'b0, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_0024, 32'h1234_5678, 4'b0000, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0024, 32'h0,         4'b0000, 1'b0, 32'hCAFE_F00D};
    vecs[12] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 4'b1111, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'b0000, 1'b0, 32'h0BAD_F00D};
    vecs[14] = '{1'b1, 32'h0000_0000, 32'h5A5A_5A5A, 4'b1111, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0};
    vecs[16] = '{1'b0, 32'h8000_0000, 32'h0,         4'b0000, 1'b1, 32'h0};

    rst = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0; resp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset_outputs("reset");
    chk("reset b req_ready", 32'(req_ready_b), 32'd1);
    chk("reset b resp_valid", 32'(resp_valid_b), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      txn(1'b0, $sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
          vecs[i].be, vecs[i].err, vecs[i].rdata, 3);
    end
    txn(1'b0, "alias0 intact", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h5A5A_5A5A, 3);

    // Backpressure: response held for 5 cycles while a competing store is offered
    resp_ready = 1'b0;
    req_wr = 1'b0; req_addr = 32'h10; req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    acc = 1;
    while (!resp_valid_a && acc < 20) begin tick(); acc++; end
    chk("bp latency", 32'(acc), 32'd3);
    req_valid_a = 1'b1; req_wr = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp valid c%0d", i), 32'(resp_valid_a), 32'd1);
      chk($sformatf("bp rdata c%0d", i), resp_rdata_a, 32'hDEAD_BEEF);
      chk($sformatf("bp req_ready c%0d", i), 32'(req_ready_a), 32'd0);
      tick();
    end
    req_valid_a = 1'b0;
    resp_ready = 1'b1;
    tick();
    rv = 0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid_a) rv++;
      tick();
    end
    chk("bp single response", 32'(rv), 32'd0);
    txn(1'b0, "bp store ignored", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 3);

    // Reset while in WAIT aborts the store
    req_wr = 1'b1; req_addr = 32'h10; req_wdata = 32'h0102_0304; req_be = 4'hF;
    req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("rst in wait");
    tick(); tick(); tick();
    chk("rst in wait no resp", 32'(resp_valid_a), 32'd0);

    // Reset coincident with the commit edge suppresses the write
    req_wr = 1'b1; req_addr = 32'h10; req_wdata = 32'h0506_0708; req_be = 4'hF;
    req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("rst on commit");
    txn(1'b0, "rst prior contents", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 3);

    // Zero wait states
    txn(1'b1, "w0 store", 1'b1, 32'h40, 32'h1357_9BDF, 4'hF, 1'b0, 32'h0, 1);
    txn(1'b1, "w0 load", 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h1357_9BDF, 1);
    txn(1'b1, "w0 misaligned", 1'b0, 32'h42, 32'h0, 4'h0, 1'b1, 32'h0, 1);

    req_wr = 1'b0; req_addr = 32'h40; req_valid_b = 1'b1;
    acc = 0; rv = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready_b) acc++;
      if (resp_valid_b) begin
        rv++;
        chk($sformatf("w0 b2b rdata c%0d", i), resp_rdata_b, 32'h1357_9BDF);
      end
      tick();
    end
    req_valid_b = 1'b0;
    chk("w0 b2b accepts", 32'(acc), 32'd4);
    chk("w0 b2b responses", 32'(rv), 32'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
